// File: rtl/lc3_execute.sv
// rtl/lc3_execute.sv - LC3 execute stage: operand forwarding, ALU, PC-relative address, stage registers.
// Optional build macro LC3_EXEC_BYPASS_EN enables the forwarding muxes on operands 1 and 2.
module lc3_execute (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_execute,
    input  logic [5:0]  E_Control,
    input  logic [15:0] IR,
    input  logic [15:0] npc_in,
    input  logic [15:0] VSR1,
    input  logic [15:0] VSR2,
    input  logic        bypass_alu_1,
    input  logic        bypass_alu_2,
    input  logic        bypass_mem_1,
    input  logic        bypass_mem_2,
    input  logic [15:0] Mem_Bypass_Val,
    input  logic [1:0]  W_Control_in,
    input  logic        Mem_Control_in,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [15:0] M_Data,
    output logic [15:0] IR_Exec,
    output logic [1:0]  W_Control_out,
    output logic        Mem_Control_out,
    output logic [2:0]  dr,
    output logic [2:0]  NZP,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2
);

    logic [1:0]  alu_control;
    logic [1:0]  pcselect1;
    logic        pcselect2;
    logic        op2select;

    logic [15:0] op1;
    logic [15:0] op2src;
    logic [15:0] op2;
    logic [15:0] alu_result;
    logic [15:0] offset;
    logic [15:0] base;
    logic [15:0] pc_result;
    logic [2:0]  nzp_next;

    assign alu_control = E_Control[5:4];
    assign pcselect1   = E_Control[3:2];
    assign pcselect2   = E_Control[1];
    assign op2select   = E_Control[0];

    assign sr1 = IR[8:6];
    assign sr2 = IR[2:0];

`ifdef LC3_EXEC_BYPASS_EN
    // Self-bypass reads the registered aluout, so the ALU path never loops combinationally.
    always_comb begin
        op1 = VSR1;
        if (bypass_alu_1)
            op1 = aluout;
        else if (bypass_mem_1)
            op1 = Mem_Bypass_Val;
    end

    always_comb begin
        op2src = VSR2;
        if (bypass_alu_2)
            op2src = aluout;
        else if (bypass_mem_2)
            op2src = Mem_Bypass_Val;
    end
`else
    logic unused_bypass;
    assign unused_bypass = &{1'b0, bypass_alu_1, bypass_alu_2, bypass_mem_1,
                             bypass_mem_2, Mem_Bypass_Val};
    assign op1    = VSR1;
    assign op2src = VSR2;
`endif

    assign op2 = op2select ? op2src : {{11{IR[4]}}, IR[4:0]};

    always_comb begin
        alu_result = 16'h0000;
        case (alu_control)
            2'b00:   alu_result = op1 + op2;
            2'b01:   alu_result = op1 & op2;
            2'b10:   alu_result = ~op1;
            default: alu_result = 16'h0000;
        endcase
    end

    always_comb begin
        offset = 16'h0000;
        case (pcselect1)
            2'b00:   offset = {{5{IR[10]}}, IR[10:0]};
            2'b01:   offset = {{7{IR[8]}}, IR[8:0]};
            2'b10:   offset = {{10{IR[5]}}, IR[5:0]};
            default: offset = 16'h0000;
        endcase
    end

    assign base      = pcselect2 ? npc_in : op1;
    assign pc_result = base + offset;
    assign nzp_next  = (IR[15:12] == 4'b0000) ? IR[11:9] : 3'b000;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aluout          <= 16'h0000;
            pcout           <= 16'h0000;
            M_Data          <= 16'h0000;
            IR_Exec         <= 16'h0000;
            W_Control_out   <= 2'b00;
            Mem_Control_out <= 1'b0;
            dr              <= 3'b000;
            NZP             <= 3'b000;
        end else if (enable_execute) begin
            aluout          <= alu_result;
            pcout           <= pc_result;
            M_Data          <= op2src;
            IR_Exec         <= IR;
            W_Control_out   <= W_Control_in;
            Mem_Control_out <= Mem_Control_in;
            dr              <= IR[11:9];
            NZP             <= nzp_next;
        end
    end

endmodule

// File: tb/tb_lc3_execute.sv
// tb/tb_lc3_execute.sv - directed-vector bench for lc3_execute.
module tb_lc3_execute;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_execute;
    logic [5:0]  E_Control;
    logic [15:0] IR;
    logic [15:0] npc_in;
    logic [15:0] VSR1;
    logic [15:0] VSR2;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic [15:0] Mem_Bypass_Val;
    logic [1:0]  W_Control_in;
    logic        Mem_Control_in;
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [15:0] M_Data;
    logic [15:0] IR_Exec;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;
    logic [2:0]  dr;
    logic [2:0]  NZP;
    logic [2:0]  sr1;
    logic [2:0]  sr2;

    int vec_count = 0;
    int err_count = 0;

    lc3_execute dut (
        .clock          (clock),
        .reset          (reset),
        .enable_execute (enable_execute),
        .E_Control      (E_Control),
        .IR             (IR),
        .npc_in         (npc_in),
        .VSR1           (VSR1),
        .VSR2           (VSR2),
        .bypass_alu_1   (bypass_alu_1),
        .bypass_alu_2   (bypass_alu_2),
        .bypass_mem_1   (bypass_mem_1),
        .bypass_mem_2   (bypass_mem_2),
        .Mem_Bypass_Val (Mem_Bypass_Val),
        .W_Control_in   (W_Control_in),
        .Mem_Control_in (Mem_Control_in),
        .aluout         (aluout),
        .pcout          (pcout),
        .M_Data         (M_Data),
        .IR_Exec        (IR_Exec),
        .W_Control_out  (W_Control_out),
        .Mem_Control_out(Mem_Control_out),
        .dr             (dr),
        .NZP            (NZP),
        .sr1            (sr1),
        .sr2            (sr2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " aluout"}, aluout, 16'h0000);
        check({tag, " pcout"}, pcout, 16'h0000);
        check({tag, " M_Data"}, M_Data, 16'h0000);
        check({tag, " IR_Exec"}, IR_Exec, 16'h0000);
        check({tag, " W_Control_out"}, {14'd0, W_Control_out}, 16'h0000);
        check({tag, " Mem_Control_out"}, {15'd0, Mem_Control_out}, 16'h0000);
        check({tag, " dr"}, {13'd0, dr}, 16'h0000);
        check({tag, " NZP"}, {13'd0, NZP}, 16'h0000);
    endtask

    initial begin
        reset          = 1'b1;
        enable_execute = 1'b0;
        E_Control      = 6'b000000;
        IR             = 16'h0000;
        npc_in         = 16'h0000;
        VSR1           = 16'h0000;
        VSR2           = 16'h0000;
        bypass_alu_1   = 1'b0;
        bypass_alu_2   = 1'b0;
        bypass_mem_1   = 1'b0;
        bypass_mem_2   = 1'b0;
        Mem_Bypass_Val = 16'h0000;
        W_Control_in   = 2'b00;
        Mem_Control_in = 1'b0;

        step();
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // ADD R1,R1,#1 with overflow into bit 15; pass-through controls ride along
        VSR1 = 16'h7FFF; IR = 16'h1261; E_Control = 6'b000000; enable_execute = 1'b1;
        W_Control_in = 2'b10; Mem_Control_in = 1'b1; VSR2 = 16'h0000;
        step();
        check("add aluout", aluout, 16'h8000);
        check("add dr", {13'd0, dr}, 16'h0001);
        check("add pcout", pcout, 16'h8260);
        check("add IR_Exec", IR_Exec, 16'h1261);
        check("add NZP", {13'd0, NZP}, 16'h0000);
        check("add W_Control_out", {14'd0, W_Control_out}, 16'h0002);
        check("add Mem_Control_out", {15'd0, Mem_Control_out}, 16'h0001);

        VSR1 = 16'hFFFF; W_Control_in = 2'b01; Mem_Control_in = 1'b0;
        step();
        check("add wrap aluout", aluout, 16'h0000);
        check("add wrap W_Control_out", {14'd0, W_Control_out}, 16'h0001);

        // BR with npc base and 9-bit offset
        VSR1 = 16'h0000; IR = 16'h0A05; npc_in = 16'h3001; E_Control = 6'b000110;
        step();
        check("br pcout", pcout, 16'h3006);
        check("br NZP", {13'd0, NZP}, 16'h0005);
        check("br dr", {13'd0, dr}, 16'h0005);
        check("br aluout", aluout, 16'h0005);

        IR = 16'h0BFF;
        step();
        check("br neg pcout", pcout, 16'h3000);
        check("br neg NZP", {13'd0, NZP}, 16'h0005);

        // Forwarding: preload aluout with 0x0010
        VSR1 = 16'h0010; IR = 16'h1260; E_Control = 6'b000000;
        step();
        check("fwd preload aluout", aluout, 16'h0010);

        Mem_Bypass_Val = 16'h0020; VSR1 = 16'h0030;
        bypass_alu_1 = 1'b1; bypass_mem_1 = 1'b1;
        step();
`ifdef LC3_EXEC_BYPASS_EN
        check("fwd both aluout", aluout, 16'h0010);
`else
        check("fwd both aluout", aluout, 16'h0030);
`endif

        bypass_alu_1 = 1'b0;
        step();
`ifdef LC3_EXEC_BYPASS_EN
        check("fwd mem aluout", aluout, 16'h0020);
`else
        check("fwd mem aluout", aluout, 16'h0030);
`endif

        bypass_mem_1 = 1'b0; bypass_alu_2 = 1'b1; bypass_mem_2 = 1'b1; VSR2 = 16'h0044;
        step();
        check("fwd op1 plain aluout", aluout, 16'h0030);
`ifdef LC3_EXEC_BYPASS_EN
        check("fwd op2 alu M_Data", M_Data, 16'h0020);
`else
        check("fwd op2 alu M_Data", M_Data, 16'h0044);
`endif

        bypass_alu_2 = 1'b0;
        step();
`ifdef LC3_EXEC_BYPASS_EN
        check("fwd op2 mem M_Data", M_Data, 16'h0020);
`else
        check("fwd op2 mem M_Data", M_Data, 16'h0044);
`endif
        bypass_mem_2 = 1'b0;

        // Stall: state is aluout 0x0030, IR_Exec 0x1260, dr 1
        enable_execute = 1'b0;
        for (int i = 0; i < 3; i++) begin
            VSR1 = 16'h1234 + 16'(i); VSR2 = 16'h5678; IR = 16'h5555 + 16'(i);
            E_Control = 6'b100000;
            step();
            check("stall aluout", aluout, 16'h0030);
            check("stall IR_Exec", IR_Exec, 16'h1260);
            check("stall dr", {13'd0, dr}, 16'h0001);
        end
        enable_execute = 1'b1; VSR1 = 16'h1234; IR = 16'h1261; E_Control = 6'b000000;
        step();
        check("resume aluout", aluout, 16'h1235);
        check("resume IR_Exec", IR_Exec, 16'h1261);

        // NOT, AND, alu 11
        VSR1 = 16'h00FF; IR = 16'h903F; E_Control = 6'b100000;
        step();
        check("not aluout", aluout, 16'hFF00);
        check("not dr", {13'd0, dr}, 16'h0000);

        VSR2 = 16'h0F0F; IR = 16'h5042; E_Control = 6'b011101;
        #1;
        check("sr1", {13'd0, sr1}, 16'h0001);
        check("sr2", {13'd0, sr2}, 16'h0002);
        step();
        check("and aluout", aluout, 16'h000F);
        check("and M_Data", M_Data, 16'h0F0F);
        check("and pcout zero offset", pcout, 16'h00FF);

        E_Control = 6'b110010; npc_in = 16'h4000; IR = 16'h1FE5;
        W_Control_in = 2'b11; Mem_Control_in = 1'b1;
        step();
        check("zero aluout", aluout, 16'h0000);
        check("ir6 pcout", pcout, 16'h3FE5);

        // Mid-cycle asynchronous reset with nonzero outputs
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("async reset");
        check("reset sr1", {13'd0, sr1}, 16'h0007);
        check("reset sr2", {13'd0, sr2}, 16'h0005);
        step();
        check("reset dominates enable", aluout, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        VSR1 = 16'h0100; IR = 16'h1261; E_Control = 6'b000000;
        step();
        check("post reset aluout", aluout, 16'h0101);
        check("post reset IR_Exec", IR_Exec, 16'h1261);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
